register_file: RTL and testbench

- 32-entry integer register file for the single-cycle RV32 core.
- Sits directly upstream of the ALU:
  - RD1 drives ALU SrcA.
  - RD2 drives the SrcB mux (register or immediate).
  - Written back at end of cycle from the result mux (ALUResult, load data or PC+4).
- Two combinational read ports, one synchronous write port, x0 hardwired to zero.
- Synchronous reset clears the whole array.

---
 rtl/register_file.sv | 52 +++++
 tb/tb_register_file.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32-entry RV32 integer register file: two combinational read ports, one
// synchronous write port, x0 reads as zero. Define REGFILE_BYPASS_EN for write-first reads.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = WE3 && (A3 != '0);

  // Reset wins over a concurrent write; regs[0] is only ever cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-first forwarding; suppressed during reset so reads show stored values.
  always_comb begin
    RD1 = regs[A1];
    RD2 = regs[A2];
    if (!reset && wr_en && (A1 == A3)) RD1 = WD3;
    if (!reset && wr_en && (A2 == A3)) RD2 = WD3;
    if (A1 == '0) RD1 = '0;
    if (A2 == '0) RD2 = '0;
  end
`else
  always_comb begin
    RD1 = (A1 == '0) ? '0 : regs[A1];
    RD2 = (A2 == '0) ? '0 : regs[A2];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file: each row drives one cycle,
// checks the combinational reads before the edge, then lets the edge commit.
module tb_register_file;

  localparam int XLEN = 32;
  localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [AW-1:0]   A1, A2, A3;
  logic            WE3;
  logic [XLEN-1:0] WD3;
  logic [XLEN-1:0] RD1, RD2;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] exp_q [$];

  typedef struct {
    logic            rst;
    logic            we;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic            chk;
    logic [XLEN-1:0] e1;   // read-old expectation
    logic [XLEN-1:0] e2;
    logic [XLEN-1:0] b1;   // expectation with write-first bypass
    logic [XLEN-1:0] b2;
  } vec_t;

  vec_t vq [$];

  register_file #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk  (clk),
    .reset(reset),
    .A1   (A1),
    .A2   (A2),
    .A3   (A3),
    .WE3  (WE3),
    .WD3  (WD3),
    .RD1  (RD1),
    .RD2  (RD2)
  );

  // Clock and initial input state
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset = 1'b1;
    WE3   = 1'b0;
    A1    = '0;
    A2    = '0;
    A3    = '0;
    WD3   = '0;
  end

  // Driver tasks
  task automatic add_vec(input logic rst, input logic we, input logic [AW-1:0] a3,
                         input logic [XLEN-1:0] wd, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic chk,
                         input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                         input logic [XLEN-1:0] b1, input logic [XLEN-1:0] b2);
    vec_t v;
    v.rst = rst; v.we = we; v.a3 = a3; v.wd = wd; v.a1 = a1; v.a2 = a2;
    v.chk = chk; v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic we, input logic [AW-1:0] a3,
                       input logic [XLEN-1:0] wd, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    @(negedge clk);
    reset = rst;
    WE3   = we;
    A3    = a3;
    WD3   = wd;
    A1    = a1;
    A2    = a2;
    #1;
  endtask

  // Scoreboard: compare one output against the oldest queued expectation
  task automatic check(input string name, input logic [XLEN-1:0] actual);
    logic [XLEN-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h, expectation queue empty", name, actual);
    end else begin
      exp = exp_q.pop_front();
      if (actual !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, actual, exp);
      end
    end
  endtask

  function automatic logic [XLEN-1:0] pat(input int i);
    return (32'h0101_0101 * i) ^ 32'hA5A5_A5A5;
  endfunction

  initial begin
    //      rst   we    a3     wd             a1     a2     chk   e1             e2             b1             b2
    add_vec(1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd31, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0);
    add_vec(1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd31, 1'b1, 32'h0,         32'h0,         32'h0,         32'h0);
    add_vec(1'b0, 1'b0, 5'd5,  32'h0,         5'd5,  5'd31, 1'b1, 32'h0,         32'h0,         32'h0,         32'h0);
    add_vec(1'b0, 1'b1, 5'd10, 32'd10,        5'd10, 5'd0,  1'b1, 32'h0,         32'h0,         32'd10,        32'h0);
    add_vec(1'b0, 1'b1, 5'd11, 32'd5,         5'd10, 5'd11, 1'b1, 32'd10,        32'h0,         32'd10,        32'd5);
    add_vec(1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd11, 5'd0,  1'b1, 32'd5,         32'h0,         32'd5,         32'h0);
    add_vec(1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  1'b1, 32'h0,         32'h0,         32'h0,         32'h0);
    add_vec(1'b0, 1'b1, 5'd7,  32'h1111_1111, 5'd0,  5'd0,  1'b1, 32'h0,         32'h0,         32'h0,         32'h0);
    add_vec(1'b0, 1'b1, 5'd7,  32'h2222_2222, 5'd7,  5'd10, 1'b1, 32'h1111_1111, 32'd10,        32'h2222_2222, 32'd10);
    add_vec(1'b0, 1'b0, 5'd3,  32'hAAAA_BBBB, 5'd7,  5'd3,  1'b1, 32'h2222_2222, 32'h0,         32'h2222_2222, 32'h0);
    add_vec(1'b0, 1'b1, 5'd1,  32'hF0F0_F0F0, 5'd3,  5'd0,  1'b1, 32'h0,         32'h0,         32'h0,         32'h0);
    add_vec(1'b0, 1'b1, 5'd2,  32'h0F0F_0F0F, 5'd1,  5'd0,  1'b1, 32'hF0F0_F0F0, 32'h0,         32'hF0F0_F0F0, 32'h0);
    add_vec(1'b0, 1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    add_vec(1'b0, 1'b0, 5'd0,  32'h0,         5'd2,  5'd2,  1'b1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
    add_vec(1'b1, 1'b1, 5'd1,  32'h1234_5678, 5'd1,  5'd2,  1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    add_vec(1'b0, 1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  1'b1, 32'h0,         32'h0,         32'h0,         32'h0);
    add_vec(1'b0, 1'b0, 5'd0,  32'h0,         5'd10, 5'd7,  1'b1, 32'h0,         32'h0,         32'h0,         32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].we, vq[i].a3, vq[i].wd, vq[i].a1, vq[i].a2);
      if (vq[i].chk) begin
        exp_q.push_back(BYP ? vq[i].b1 : vq[i].e1);
        check($sformatf("vec%0d rd1", i), RD1);
        exp_q.push_back(BYP ? vq[i].b2 : vq[i].e2);
        check($sformatf("vec%0d rd2", i), RD2);
      end
    end

    // Fill every register, then read all addresses on both ports in opposite orders
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, AW'(i), pat(i), 5'd0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, AW'(i), AW'(31 - i));
      exp_q.push_back((i == 0) ? 32'h0 : pat(i));
      check($sformatf("fill rd1 x%0d", i), RD1);
      exp_q.push_back((i == 31) ? 32'h0 : pat(31 - i));
      check($sformatf("fill rd2 x%0d", 31 - i), RD2);
    end

    // x0 stays zero even while a write to x0 is being presented
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    exp_q.push_back(32'h0);
    check("x0 write-cycle rd1", RD1);
    exp_q.push_back(32'h0);
    check("x0 write-cycle rd2", RD2);

    // Full reset clears everything that was filled
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, AW'(i), AW'(31 - i));
      exp_q.push_back(32'h0);
      check($sformatf("post-reset rd1 x%0d", i), RD1);
      exp_q.push_back(32'h0);
      check($sformatf("post-reset rd2 x%0d", 31 - i), RD2);
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
